// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped LED output port:
// RAM decode addresses, status byte layout and the default frame divider.
package io_pkg;

    localparam logic [15:0] LED_DATA_ADDR    = 16'hFF10;
    localparam logic [15:0] LED_STAT_ADDR    = 16'hFF11;

    localparam int STAT_FRAME       = 7;
    localparam int STAT_PEND        = 6;
    localparam int STAT_OVR_MSB     = 3;
    localparam int STAT_OVR_LSB     = 0;

    localparam int DEFAULT_TICK_DIV = 12_000_000;

    typedef struct packed {
        logic       frame_flag;
        logic       pending;
        logic [1:0] rsvd;
        logic [3:0] overrun;
    } led_status_t;

    // Overrun counter increment that sticks at all-ones instead of wrapping
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : (v + 4'h1);
    endfunction

endpackage

// File: rtl/led_out_port_if.sv
// CPU-side bus of the LED output port; master is the RAM decode / CPU,
// slave is the port itself.
interface led_out_port_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_ack;
    logic [7:0] leds;
    logic [7:0] status;
    logic       frame_tick;

    modport master (
        output wr_en, wr_data, frame_ack,
        input  leds, status, frame_tick
    );

    modport slave (
        input  wr_en, wr_data, frame_ack,
        output leds, status, frame_tick
    );

endinterface

// File: rtl/led_out_port_tick_gen.sv
// Frame divider: tick_pre flags the last count of a frame, frame_tick is its
// registered one-cycle pulse in the following cycle.
module tick_gen #(
    parameter int TICK_DIV = 12_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_pre,
    output logic frame_tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          frame_tick_q;

    // Next count: wrap to zero after the last count of the frame
    always_comb begin
        tick_pre = (cnt_q == LAST);
        if (tick_pre) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Counter and registered tick pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= {CW{1'b0}};
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            frame_tick_q <= tick_pre;
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/led_out_port.sv
// LED output port: CPU writes land in a shadow register and are committed to
// the LEDs once per frame; status reports frame flag, pending and overruns.
module led_out_port
    import io_pkg::*;
#(
    parameter int         TICK_DIV  = DEFAULT_TICK_DIV,
    parameter logic [7:0] LED_RESET = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    led_out_port_if.slave  bus
);

    logic       commit_s;
    logic       frame_tick_s;
    logic       ovr_event_s;

    logic [7:0] leds_q,       leds_d;
    logic [7:0] shadow_q,     shadow_d;
    logic       pending_q,    pending_d;
    logic       frame_flag_q, frame_flag_d;
    logic [3:0] overrun_q,    overrun_d;

    led_status_t status_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .tick_pre   (commit_s),
        .frame_tick (frame_tick_s)
    );

    // Next-state: a write in the commit cycle bypasses the shadow straight to the LEDs
    always_comb begin
        leds_d       = leds_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_flag_d = frame_flag_q;
        overrun_d    = overrun_q;
        ovr_event_s  = bus.wr_en && pending_q && !commit_s;

        if (bus.wr_en) begin
            shadow_d = bus.wr_data;
        end else begin
            shadow_d = shadow_q;
        end

        if (commit_s) begin
            pending_d    = 1'b0;
            frame_flag_d = 1'b1;
            if (bus.wr_en) begin
                leds_d = bus.wr_data;
            end else if (pending_q) begin
                leds_d = shadow_q;
            end else begin
                leds_d = leds_q;
            end
        end else begin
            pending_d    = bus.wr_en ? 1'b1 : pending_q;
            frame_flag_d = bus.frame_ack ? 1'b0 : frame_flag_q;
            leds_d       = leds_q;
        end

        if (bus.frame_ack) begin
            overrun_d = ovr_event_s ? 4'h1 : 4'h0;
        end else if (ovr_event_s) begin
            overrun_d = sat_inc4(overrun_q);
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Port state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q       <= LED_RESET;
            shadow_q     <= 8'h00;
            pending_q    <= 1'b0;
            frame_flag_q <= 1'b0;
            overrun_q    <= 4'h0;
        end else begin
            leds_q       <= leds_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_flag_q <= frame_flag_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        status_s.frame_flag = frame_flag_q;
        status_s.pending    = pending_q;
        status_s.rsvd       = 2'b00;
        status_s.overrun    = overrun_q;
    end

    assign bus.leds       = leds_q;
    assign bus.status     = status_s;
    assign bus.frame_tick = frame_tick_s;

endmodule

// File: tb/tb_led_out_port.sv
// Directed table-driven bench for led_out_port with an 8-cycle frame.
module tb_led_out_port;

    logic clk;
    logic reset;

    led_out_port_if bus ();

    led_out_port #(.TICK_DIV(8), .LED_RESET(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic       chk;
        logic [7:0] el;
        logic [7:0] es;
        logic       et;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic we, input logic [7:0] wd,
                       input logic ack, input logic chk, input logic [7:0] el,
                       input logic [7:0] es, input logic et);
        vec_t v;
        v.rst = rst; v.we = we; v.wd = wd; v.ack = ack;
        v.chk = chk; v.el = el; v.es = es; v.et = et;
        vecs.push_back(v);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic cycle(input logic rst, input logic we, input logic [7:0] wd, input logic ack);
        @(negedge clk);
        reset         = rst;
        bus.wr_en     = we;
        bus.wr_data   = wd;
        bus.frame_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  seen;

        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.frame_ack = 1'b0;

        // Idle after reset: ticks after cycles 7 and 15, flag set from the first tick
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 20; k++)
            add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00,
                (k >= 7) ? 8'h80 : 8'h00, (k == 7) || (k == 15));

        // Single write at cycle 3, committed on the tick edge
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 8'h40, 1'b0);
        for (int k = 4; k < 7; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h40, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h80, 1'b1);   // k=7
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h80, 1'b0);   // k=8

        // Three writes in one frame -> two overruns, last value wins, ack clears
        add(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5, 8'hC0, 1'b0);   // k=9
        add(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'hA5, 8'hC1, 1'b0);
        add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'hA5, 8'hC2, 1'b0);
        for (int k = 12; k < 15; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 8'hC2, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 8'h82, 1'b1);   // k=15 commit
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0);   // k=16 ack off-tick

        // Write during the commit cycle is forwarded; overrun unchanged
        for (int k = 17; k < 20; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);
        add(1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'h33, 8'h40, 1'b0);   // k=20
        add(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h33, 8'h41, 1'b0);   // k=21
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 8'h41, 1'b0);   // k=22
        add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 8'h81, 1'b1);   // k=23 commit+write
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h81, 1'b0);   // k=24

        // Ack coincident with commit: flag stays set, overrun cleared
        for (int k = 25; k < 31; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h81, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h80, 1'b1);   // k=31
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h00, 1'b0);   // k=32

        // Write every non-commit cycle over three frames: 17 overruns saturate at F
        for (int k = 33; k < 56; k++) begin
            logic       w;
            logic       c;
            logic [7:0] el;
            logic [7:0] es;
            logic       et;
            w  = (k % 8) != 7;
            c  = (k == 46) || (k == 52) || (k == 54) || (k == 55);
            el = (k == 46) ? 8'h26 : ((k == 55) ? 8'h36 : 8'h2E);
            es = (k == 46) ? 8'hCB : ((k == 55) ? 8'h8F : 8'hCF);
            et = (k == 55);
            add(1'b0, w, 8'(k), 1'b0, c, el, es, et);
        end

        // Apply the table
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].ack);
            if (vecs[i].chk) begin
                check8($sformatf("vec%0d leds", i), bus.leds, vecs[i].el);
                check8($sformatf("vec%0d status", i), bus.status, vecs[i].es);
                check8($sformatf("vec%0d tick", i), {7'b0, bus.frame_tick}, {7'b0, vecs[i].et});
            end
        end

        // Reset mid-frame discards an uncommitted write
        for (int k = 56; k < 59; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);                            // k=59
        check8("pre_reset status", bus.status, 8'hCF);
        check8("pre_reset leds", bus.leds, 8'h36);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);                            // k=60
        cycle(1'b1, 1'b0, 8'h00, 1'b0);                            // k=61, cnt=5
        check8("reset leds", bus.leds, 8'h00);
        check8("reset status", bus.status, 8'h00);
        check8("reset tick", {7'b0, bus.frame_tick}, 8'h00);

        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
            seen = bus.frame_tick;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL post_reset tick: no frame_tick within %0d cycles, expected after 8", n);
        end else begin
            check8("post_reset tick latency", 8'(n), 8'd8);
            check8("post_reset leds", bus.leds, 8'h00);
            check8("post_reset status", bus.status, 8'h80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
